// File: rtl/led_seq_ctrl.sv
// led_seq_ctrl: sequencer in front of module_leds on the Tang 9K Hamming board.
// Captures one decoded Hamming word (data, syndrome, error flag) and
// time-multiplexes it onto the 4-bit binario bus. A clean word is shown
// steadily. A corrected word alternates between a DATA view and a SYN view
// in which the syndrome blinks.
//
// Handshake: the source raises valid_i and holds the word stable until it
// sees ack_o. The word is captured on the first rising edge where
// valid_i=1 and ack_o=0. ack_o is then high for exactly one cycle, and
// valid_i is ignored during that cycle. The source drops valid_i on the
// cycle after it sees ack_o, so a valid_i held high is accepted at most
// once every two cycles.
//
// modo_o is the FSM state register itself (00 IDLE, 01 DATA, 10 SYN), so the
// current state is always visible at the port.

module led_seq_ctrl #(
    parameter int DWELL_CYC = 27_000_000,
    parameter int BLINK_CYC = 6_750_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_i,
    input  logic [3:0] dato_i,
    input  logic [2:0] sindrome_i,
    input  logic       error_i,
    output logic       ack_o,
    output logic [3:0] binario_o,
    output logic [1:0] modo_o
);

    localparam int DW = $clog2(DWELL_CYC);
    localparam int BW = $clog2(BLINK_CYC);
    localparam logic [DW-1:0] DWELL_LAST = DW'(DWELL_CYC - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_DATA = 2'b01,
        S_SYN  = 2'b10
    } state_t;

    state_t        state;
    logic [DW-1:0] dwell_cnt;
    logic [BW-1:0] blink_cnt;
    logic          blink_on;
    logic [3:0]    dato_q;
    logic [2:0]    syn_q;
    logic          err_q;

    logic capture;
    logic dwell_last;
    logic blink_last;

    // Capture qualifier and terminal-count decodes
    assign capture    = valid_i && !ack_o;
    assign dwell_last = (dwell_cnt == DWELL_LAST);
    assign blink_last = (blink_cnt == BLINK_LAST);

    // The state register is the view code
    assign modo_o = state;

    // Single FSM: capture has priority over every timed transition; all outputs registered
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            dwell_cnt <= '0;
            blink_cnt <= '0;
            blink_on  <= 1'b1;
            dato_q    <= 4'b0000;
            syn_q     <= 3'b000;
            err_q     <= 1'b0;
            ack_o     <= 1'b0;
            binario_o <= 4'b0000;
        end else begin
            ack_o <= 1'b0;
            if (capture) begin
                // New word: shown on the same cycle ack_o is high
                dato_q    <= dato_i;
                syn_q     <= sindrome_i;
                err_q     <= error_i;
                ack_o     <= 1'b1;
                state     <= S_DATA;
                dwell_cnt <= '0;
                blink_cnt <= '0;
                blink_on  <= 1'b1;
                binario_o <= dato_i;
            end else begin
                case (state)
                    S_IDLE: begin
                        binario_o <= 4'b0000;
                    end
                    S_DATA: begin
                        if (dwell_last) begin
                            dwell_cnt <= '0;
                            if (err_q) begin
                                // SYN always starts in the ON phase
                                state     <= S_SYN;
                                blink_cnt <= '0;
                                blink_on  <= 1'b1;
                                binario_o <= {1'b1, syn_q};
                            end else begin
                                binario_o <= dato_q;
                            end
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                            binario_o <= dato_q;
                        end
                    end
                    S_SYN: begin
                        if (dwell_last) begin
                            state     <= S_DATA;
                            dwell_cnt <= '0;
                            blink_cnt <= '0;
                            blink_on  <= 1'b1;
                            binario_o <= dato_q;
                        end else begin
                            dwell_cnt <= dwell_cnt + 1'b1;
                            if (blink_last) begin
                                // Half-period elapsed: toggle phase and the displayed nibble
                                blink_cnt <= '0;
                                blink_on  <= !blink_on;
                                binario_o <= blink_on ? 4'b0000 : {1'b1, syn_q};
                            end else begin
                                blink_cnt <= blink_cnt + 1'b1;
                            end
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        binario_o <= 4'b0000;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_led_seq_ctrl.sv
// tb_led_seq_ctrl: directed bench for led_seq_ctrl with DWELL_CYC=8, BLINK_CYC=2.
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_led_seq_ctrl;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst;
    logic       valid_i;
    logic [3:0] dato_i;
    logic [2:0] sindrome_i;
    logic       error_i;
    logic       ack_o;
    logic [3:0] binario_o;
    logic [1:0] modo_o;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    led_seq_ctrl #(
        .DWELL_CYC(8),
        .BLINK_CYC(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .valid_i    (valid_i),
        .dato_i     (dato_i),
        .sindrome_i (sindrome_i),
        .error_i    (error_i),
        .ack_o      (ack_o),
        .binario_o  (binario_o),
        .modo_o     (modo_o)
    );

    // Time limit: a runaway run still reports and stops
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected end of test");
        $fatal(1, "watchdog expired");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_view(input string tag, input logic [3:0] bin, input logic [1:0] modo);
        check({tag, ".binario"}, 32'(binario_o), 32'(bin));
        check({tag, ".modo"}, 32'(modo_o), 32'(modo));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    // Present a word, let one edge capture it, check the ack cycle, release valid
    task automatic capture(input string tag, input logic [3:0] d, input logic [2:0] s, input logic e);
        valid_i    = 1'b1;
        dato_i     = d;
        sindrome_i = s;
        error_i    = e;
        step();
        check({tag, ".ack"}, 32'(ack_o), 32'd1);
        expect_view({tag, ".cap"}, d, 2'b01);
        valid_i = 1'b0;
    endtask

    logic [3:0] syn_pat[8];

    // ---------------- stimulus ----------------
    initial begin
        syn_pat = '{4'hD, 4'hD, 4'h0, 4'h0, 4'hD, 4'hD, 4'h0, 4'h0};
        rst        = 1'b1;
        valid_i    = 1'b0;
        dato_i     = 4'h0;
        sindrome_i = 3'b000;
        error_i    = 1'b0;
        step();
        step();
        check("por.ack", 32'(ack_o), 32'd0);
        expect_view("por", 4'h0, 2'b00);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_view("idle_after_por", 4'h0, 2'b00);
        end

        // Clean word: steady DATA, never SYN
        capture("clean", 4'b1010, 3'b000, 1'b0);
        step();
        check("clean.ack_one_cycle", 32'(ack_o), 32'd0);
        for (int i = 0; i < 40; i++) begin
            expect_view("clean.hold", 4'b1010, 2'b01);
            step();
        end

        // Error word: 8 cycles DATA, 8 cycles blinking SYN, 8 cycles DATA, SYN again
        capture("err", 4'b0110, 3'b101, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step();
            expect_view("err.data1", 4'b0110, 2'b01);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            expect_view("err.syn1", syn_pat[i], 2'b10);
        end
        for (int i = 0; i < 8; i++) begin
            step();
            expect_view("err.data2", 4'b0110, 2'b01);
        end
        step();
        expect_view("err.syn2_c0", 4'hD, 2'b10);
        step();
        expect_view("err.syn2_c1", 4'hD, 2'b10);

        // Asynchronous reset mid-SYN takes effect at once
        rst = 1'b1;
        #1;
        check("rst_async.ack", 32'(ack_o), 32'd0);
        expect_view("rst_async", 4'h0, 2'b00);
        step();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            expect_view("rst_idle", 4'h0, 2'b00);
        end

        // Held valid: ack pulses every other cycle
        valid_i    = 1'b1;
        dato_i     = 4'b0101;
        sindrome_i = 3'b000;
        error_i    = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            check("held.ack", 32'(ack_o), (i % 2 == 0) ? 32'd1 : 32'd0);
            expect_view("held", 4'b0101, 2'b01);
        end
        valid_i = 1'b0;

        // Override: clean capture in the 3rd SYN cycle returns to steady DATA
        capture("ovr_err", 4'b0110, 3'b101, 1'b1);
        for (int i = 1; i < 8; i++) step();
        step();
        expect_view("ovr.syn_c0", 4'hD, 2'b10);
        step();
        expect_view("ovr.syn_c1", 4'hD, 2'b10);
        step();
        expect_view("ovr.syn_c2", 4'h0, 2'b10);
        capture("ovr", 4'b0011, 3'b000, 1'b0);
        for (int i = 0; i < 20; i++) begin
            step();
            expect_view("ovr.hold", 4'b0011, 2'b01);
        end

        // Capture on the terminal DATA cycle with err_q=1: capture wins, dwell restarts
        capture("term_a", 4'b1001, 3'b011, 1'b1);
        for (int i = 1; i < 8; i++) step();
        expect_view("term.c7", 4'b1001, 2'b01);
        capture("term_b", 4'b1100, 3'b011, 1'b1);
        for (int i = 1; i < 8; i++) begin
            step();
            expect_view("term.restart", 4'b1100, 2'b01);
        end
        step();
        expect_view("term.syn", 4'b1011, 2'b10);

        // err with zero syndrome still shows SYN as 1000
        capture("syn0", 4'b0001, 3'b000, 1'b1);
        for (int i = 1; i < 8; i++) step();
        expect_view("syn0.c7", 4'b0001, 2'b01);
        step();
        expect_view("syn0.syn", 4'b1000, 2'b10);
        step();
        expect_view("syn0.syn_c1", 4'b1000, 2'b10);
        step();
        expect_view("syn0.syn_off", 4'b0000, 2'b10);

        // ---------------- final report ----------------
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
